alu_uart_ctrl: RTL and testbench
================================

ALU_UART_CTRL -- requirements
Module: alu_uart_ctrl

Interface
REQ-001 Parameter NB_DATA, default 8: operand, result and serial byte width.
REQ-002 Parameter NB_CODE, default 6: opcode width; the opcode is the NB_CODE LSBs of the opcode byte.
REQ-003 Parameter NB_TIMEOUT, default 16: inter-byte timeout counter width.
REQ-004 Parameter TIMEOUT_CYCLES, default 50000: maximum idle clocks between frame bytes; must be less than 2**NB_TIMEOUT.
REQ-005 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-006 i_clk  in  1  system clock; all logic on the rising edge.
REQ-007 i_reset_n  in  1  asynchronous active-low reset.
REQ-008 i_rx_done  in  1  one-cycle pulse: i_rx_data holds a received byte.
REQ-009 i_rx_data  in  NB_DATA  received byte.
REQ-010 i_tx_done  in  1  one-cycle pulse: transmitter finished the current byte.
REQ-011 o_tx_start  out  1  one-cycle pulse: transmitter loads o_tx_data.
REQ-012 o_tx_data  out  NB_DATA  result byte to transmit; held stable from o_tx_start until i_tx_done.
REQ-013 o_result  out  NB_DATA  last registered ALU result.
REQ-014 o_result_valid  out  1  one-cycle pulse when o_result updates.
REQ-015 o_busy  out  1  high in EXEC, SEND and WAIT_TX.
REQ-016 o_frame_err  out  1  one-cycle pulse on timeout (or checksum mismatch, see REQ-030).
REQ-017 o_overrun  out  1  one-cycle pulse when a byte arrives while o_busy is high.

Function
REQ-018 States SHALL be GET_A, GET_B, GET_OP, EXEC, SEND and WAIT_TX; GET_CHK is added under REQ-030.
REQ-019 GET_A: on i_rx_done, latch the byte into A and go to GET_B.
REQ-020 GET_B: on i_rx_done, latch B and go to GET_OP.
REQ-021 GET_OP: on i_rx_done, latch the opcode and go to EXEC.
REQ-022 EXEC, one cycle:
  - register the ALU output into o_result and o_tx_data;
  - pulse o_result_valid;
  - go to SEND.
REQ-023 SEND, one cycle: pulse o_tx_start and go to WAIT_TX.
REQ-024 WAIT_TX: on i_tx_done, go to GET_A.
REQ-025 Latency: o_result_valid is 1 cycle after the opcode i_rx_done; o_tx_start is 2 cycles after it.
REQ-026 Timeout counter:
  - cleared on every i_rx_done and on entry to GET_A;
  - counts in GET_B, GET_OP and GET_CHK;
  - on reaching TIMEOUT_CYCLES: pulse o_frame_err, discard the partial frame, go to GET_A.
REQ-027 An i_rx_done that coincides with the timeout cycle SHALL be accepted; the timeout is suppressed.
REQ-028 i_rx_done while o_busy is high: the byte is dropped, o_overrun pulses, and the state is unchanged.
REQ-029 Unknown state encoding SHALL recover to GET_A with A, B and opcode cleared.

Configuration
REQ-030 With macro ALU_UART_CHECKSUM_EN defined:
  - GET_CHK follows GET_OP;
  - the fourth byte must equal A ^ B ^ opcode byte;
  - on a match, go to EXEC;
  - on a mismatch, pulse o_frame_err, produce no result and go to GET_A.
REQ-031 Without ALU_UART_CHECKSUM_EN the frame SHALL be three bytes and GET_CHK SHALL not exist.

Reset
REQ-032 While i_reset_n is low:
  - state = GET_A;
  - A, B, opcode, o_result, o_tx_data and the timeout counter = 0;
  - all pulse outputs and o_busy = 0.
REQ-033 Reset mid-frame or mid-transmit SHALL abandon the frame; no o_tx_start is issued after release until a new full frame arrives.

Structure
REQ-034 A shared package SHALL hold:
  - the state encodings;
  - the opcode constants (ADD 6'h20, SUB 6'h22, AND 6'h24, OR 6'h25, XOR 6'h26, NOR 6'h27, SRA 6'h03, SRL 6'h02);
  - the default frame length.
REQ-035 Sub-module alu SHALL be instantiated (NB_DATA, NB_DATA_OUT = NB_DATA), driven from the registered A, B and opcode.

Verification
REQ-036 Bytes 0x05, 0x03, 0x20 -> o_result_valid with o_result = 0x08; o_tx_start next cycle with o_tx_data = 0x08; i_tx_done returns to GET_A.
REQ-037 Bytes 0x05, 0x07, 0x22 -> o_result = 0xFE.
REQ-038 Bytes 0x10, then a gap of TIMEOUT_CYCLES -> o_frame_err pulse; then 0x0F, 0xF0, 0x25 -> o_result = 0xFF.
REQ-039 Extra byte 0xAA while WAIT_TX -> o_overrun pulse; the next frame 0x01, 0x01, 0x20 -> o_result = 0x02.
REQ-040 Reset asserted after byte A -> outputs cleared; bytes 0x03, 0x03, 0x26 -> o_result = 0x00.
REQ-041 With ALU_UART_CHECKSUM_EN: 0x05, 0x03, 0x20, 0x26 -> o_result = 0x08; checksum 0x27 -> o_frame_err pulse and no o_result_valid.

Source files
------------

// File: rtl/alu_uart_ctrl_pkg.sv
// Shared types and constants for the ALU-over-UART frame controller.
// ALU_UART_CHECKSUM_EN adds a fourth, XOR checksum byte to every frame.
package alu_uart_ctrl_pkg;

`ifdef ALU_UART_CHECKSUM_EN
    typedef enum logic [2:0] {
        GET_A   = 3'd0,
        GET_B   = 3'd1,
        GET_OP  = 3'd2,
        EXEC    = 3'd3,
        SEND    = 3'd4,
        WAIT_TX = 3'd5,
        GET_CHK = 3'd6
    } state_e;

    localparam int FRAME_LEN = 4;
`else
    typedef enum logic [2:0] {
        GET_A   = 3'd0,
        GET_B   = 3'd1,
        GET_OP  = 3'd2,
        EXEC    = 3'd3,
        SEND    = 3'd4,
        WAIT_TX = 3'd5
    } state_e;

    localparam int FRAME_LEN = 3;
`endif

    localparam logic [5:0] OP_ADD = 6'h20;
    localparam logic [5:0] OP_SUB = 6'h22;
    localparam logic [5:0] OP_AND = 6'h24;
    localparam logic [5:0] OP_OR  = 6'h25;
    localparam logic [5:0] OP_XOR = 6'h26;
    localparam logic [5:0] OP_NOR = 6'h27;
    localparam logic [5:0] OP_SRA = 6'h03;
    localparam logic [5:0] OP_SRL = 6'h02;

endpackage

// File: rtl/alu_uart_ctrl_alu.sv
// Combinational ALU used by the frame controller.
// Unknown opcodes yield zero.
module alu
    import alu_uart_ctrl_pkg::*;
#(
    parameter int NB_DATA     = 8,
    parameter int NB_DATA_OUT = NB_DATA,
    parameter int NB_CODE     = 6
) (
    input  logic [NB_DATA-1:0]     i_a,
    input  logic [NB_DATA-1:0]     i_b,
    input  logic [NB_CODE-1:0]     i_op,
    output logic [NB_DATA_OUT-1:0] o_res
);

    logic [NB_DATA-1:0] res;

    always_comb begin
        res = '0;
        case (i_op)
            NB_CODE'(OP_ADD): res = i_a + i_b;
            NB_CODE'(OP_SUB): res = i_a - i_b;
            NB_CODE'(OP_AND): res = i_a & i_b;
            NB_CODE'(OP_OR):  res = i_a | i_b;
            NB_CODE'(OP_XOR): res = i_a ^ i_b;
            NB_CODE'(OP_NOR): res = ~(i_a | i_b);
            NB_CODE'(OP_SRA): res = $signed(i_a) >>> i_b;
            NB_CODE'(OP_SRL): res = i_a >> i_b;
            default:          res = '0;
        endcase
    end

    assign o_res = NB_DATA_OUT'(res);

endmodule

// File: rtl/alu_uart_ctrl.sv
// Collects A, B, opcode bytes from a UART receiver, runs the ALU, sends the result.
// ALU_UART_CHECKSUM_EN adds a checked fourth byte (A ^ B ^ opcode byte).
module alu_uart_ctrl
    import alu_uart_ctrl_pkg::*;
#(
    parameter int NB_DATA        = 8,
    parameter int NB_CODE        = 6,
    parameter int NB_TIMEOUT     = 16,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_rx_done,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_tx_done,
    output logic               o_tx_start,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic [NB_DATA-1:0] o_result,
    output logic               o_result_valid,
    output logic               o_busy,
    output logic               o_frame_err,
    output logic               o_overrun
);

    localparam logic [NB_TIMEOUT-1:0] TMO_LAST =
        NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

    state_e              state_q, state_d;
    logic [NB_DATA-1:0]  a_q, a_d;
    logic [NB_DATA-1:0]  b_q, b_d;
    logic [NB_CODE-1:0]  op_q, op_d;
    logic [NB_DATA-1:0]  result_q, result_d;
    logic [NB_DATA-1:0]  tx_data_q, tx_data_d;
    logic [NB_TIMEOUT-1:0] tmo_q, tmo_d;
    logic                valid_q, valid_d;
    logic                start_q, start_d;
    logic                ferr_q, ferr_d;
    logic                ovr_q, ovr_d;
    logic                busy;
    logic                tmo_hit;
    logic                abort;
    logic [NB_DATA-1:0]  alu_res;
`ifdef ALU_UART_CHECKSUM_EN
    logic [NB_DATA-1:0]  opb_q, opb_d;
`endif

    alu #(
        .NB_DATA     (NB_DATA),
        .NB_DATA_OUT (NB_DATA),
        .NB_CODE     (NB_CODE)
    ) u_alu (
        .i_a   (a_q),
        .i_b   (b_q),
        .i_op  (op_q),
        .o_res (alu_res)
    );

    assign busy    = state_q inside {EXEC, SEND, WAIT_TX};
    assign tmo_hit = (tmo_q == TMO_LAST);

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        result_d  = result_q;
        tx_data_d = tx_data_q;
        tmo_d     = '0;
        valid_d   = 1'b0;
        start_d   = 1'b0;
        ferr_d    = 1'b0;
        ovr_d     = i_rx_done && busy;
        abort     = 1'b0;
`ifdef ALU_UART_CHECKSUM_EN
        opb_d     = opb_q;
`endif
        case (state_q)
            GET_A: begin
                if (i_rx_done) begin
                    a_d     = i_rx_data;
                    state_d = GET_B;
                end
            end
            GET_B: begin
                if (i_rx_done) begin
                    b_d     = i_rx_data;
                    state_d = GET_OP;
                end else if (tmo_hit) begin
                    abort = 1'b1;
                end else begin
                    tmo_d = tmo_q + NB_TIMEOUT'(1);
                end
            end
            GET_OP: begin
                if (i_rx_done) begin
                    op_d    = i_rx_data[NB_CODE-1:0];
`ifdef ALU_UART_CHECKSUM_EN
                    opb_d   = i_rx_data;
                    state_d = GET_CHK;
`else
                    state_d = EXEC;
`endif
                end else if (tmo_hit) begin
                    abort = 1'b1;
                end else begin
                    tmo_d = tmo_q + NB_TIMEOUT'(1);
                end
            end
`ifdef ALU_UART_CHECKSUM_EN
            GET_CHK: begin
                if (i_rx_done) begin
                    if (i_rx_data == (a_q ^ b_q ^ opb_q)) begin
                        state_d = EXEC;
                    end else begin
                        abort = 1'b1;
                    end
                end else if (tmo_hit) begin
                    abort = 1'b1;
                end else begin
                    tmo_d = tmo_q + NB_TIMEOUT'(1);
                end
            end
`endif
            EXEC: begin
                result_d  = alu_res;
                tx_data_d = alu_res;
                valid_d   = 1'b1;
                state_d   = SEND;
            end
            SEND: begin
                start_d = 1'b1;
                state_d = WAIT_TX;
            end
            WAIT_TX: begin
                if (i_tx_done) begin
                    state_d = GET_A;
                end
            end
            default: begin
                state_d = GET_A;
                a_d     = '0;
                b_d     = '0;
                op_d    = '0;
            end
        endcase
        // Timeout or bad checksum throws away whatever part of the frame arrived.
        if (abort) begin
            ferr_d  = 1'b1;
            state_d = GET_A;
            a_d     = '0;
            b_d     = '0;
            op_d    = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= GET_A;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            result_q  <= '0;
            tx_data_q <= '0;
            tmo_q     <= '0;
            valid_q   <= 1'b0;
            start_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
`ifdef ALU_UART_CHECKSUM_EN
            opb_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            result_q  <= result_d;
            tx_data_q <= tx_data_d;
            tmo_q     <= tmo_d;
            valid_q   <= valid_d;
            start_q   <= start_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
`ifdef ALU_UART_CHECKSUM_EN
            opb_q     <= opb_d;
`endif
        end
    end

    assign o_tx_start     = start_q;
    assign o_tx_data      = tx_data_q;
    assign o_result       = result_q;
    assign o_result_valid = valid_q;
    assign o_busy         = busy;
    assign o_frame_err    = ferr_q;
    assign o_overrun      = ovr_q;

endmodule

// File: tb/tb_alu_uart_ctrl.sv
// Directed bench for alu_uart_ctrl with a result scoreboard.
// Define ALU_UART_CHECKSUM_EN to exercise the four-byte frame.
module tb_alu_uart_ctrl;

    localparam int TMO = 20;

    logic       clk;
    logic       rst_n;
    logic       rx_done;
    logic [7:0] rx_data;
    logic       tx_done;
    logic       o_tx_start;
    logic [7:0] o_tx_data;
    logic [7:0] o_result;
    logic       o_result_valid;
    logic       o_busy;
    logic       o_frame_err;
    logic       o_overrun;

    int total = 0;
    int bad   = 0;
    int ferr  = 0;
    int ovr   = 0;
    int nres  = 0;
    logic [7:0] exp_q[$];
    logic [7:0] last_exp;
    logic       pend = 1'b0;
    logic [7:0] pend_val;

    alu_uart_ctrl #(
        .NB_DATA        (8),
        .NB_CODE        (6),
        .NB_TIMEOUT     (16),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .i_clk          (clk),
        .i_reset_n      (rst_n),
        .i_rx_done      (rx_done),
        .i_rx_data      (rx_data),
        .i_tx_done      (tx_done),
        .o_tx_start     (o_tx_start),
        .o_tx_data      (o_tx_data),
        .o_result       (o_result),
        .o_result_valid (o_result_valid),
        .o_busy         (o_busy),
        .o_frame_err    (o_frame_err),
        .o_overrun      (o_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (pend) begin
                check("tx_start_after_valid", o_tx_start, 1);
                check("tx_data", o_tx_data, pend_val);
                pend = 1'b0;
            end else if (o_tx_start) begin
                check("spurious_tx_start", o_tx_start, 0);
            end
            if (o_result_valid) begin
                nres++;
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", o_result_valid, 0);
                end else begin
                    pend_val = exp_q.pop_front();
                    check("result", o_result, pend_val);
                    pend = 1'b1;
                end
            end
            if (o_frame_err) ferr++;
            if (o_overrun) ovr++;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1 rx_data = b;
        rx_done = 1'b1;
        @(posedge clk);
        #1 rx_done = 1'b0;
    endtask

    task automatic send_tail(input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] op, input logic [7:0] r);
        exp_q.push_back(r);
        last_exp = r;
        send_byte(op);
`ifdef ALU_UART_CHECKSUM_EN
        send_byte(a ^ b ^ op);
`endif
        @(negedge clk);
        check("valid_early", o_result_valid, 0);
        check("busy_exec", o_busy, 1);
        @(negedge clk);
        check("valid_lat", o_result_valid, 1);
        @(negedge clk);
        check("tx_start_lat", o_tx_start, 1);
    endtask

    task automatic send3(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] op, input logic [7:0] r);
        send_byte(a);
        send_byte(b);
        send_tail(a, b, op, r);
    endtask

    task automatic finish_tx();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("busy_wait_tx", o_busy, 1);
        check("tx_data_hold", o_tx_data, last_exp);
        @(posedge clk);
        #1 tx_done = 1'b1;
        @(posedge clk);
        #1 tx_done = 1'b0;
        @(negedge clk);
        check("idle_after_tx", o_busy, 0);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_result"}, o_result, 0);
        check({tag, "_tx_data"}, o_tx_data, 0);
        check({tag, "_busy"}, o_busy, 0);
        check({tag, "_pulses"},
              {o_tx_start, o_result_valid, o_frame_err, o_overrun}, 0);
    endtask

    logic [7:0] ta[4] = '{8'hCC, 8'h0F, 8'h3C, 8'h80};
    logic [7:0] tb[4] = '{8'hAA, 8'hF0, 8'hFF, 8'h02};
    logic [7:0] to[4] = '{8'h24, 8'h27, 8'h26, 8'h03};
    logic [7:0] tr[4] = '{8'h88, 8'h00, 8'hC3, 8'hE0};

    initial begin
        int n;
        int r0;
        rst_n   = 1'b0;
        rx_done = 1'b0;
        rx_data = 8'h00;
        tx_done = 1'b0;
        repeat (3) @(negedge clk);
        check_cleared("reset");
        rst_n = 1'b1;

        send3(8'h05, 8'h03, 8'h20, 8'h08);
        finish_tx();
        send3(8'h05, 8'h07, 8'h22, 8'hFE);
        finish_tx();

        send_byte(8'h10);
        n = 0;
        for (int i = 1; i <= 3 * TMO; i++) begin
            @(negedge clk);
            if (o_frame_err) begin
                n = i;
                break;
            end
        end
        check("timeout_lat", n, TMO + 1);
        check("timeout_idle", o_busy, 0);
        send3(8'h0F, 8'hF0, 8'h25, 8'hFF);
        finish_tx();
        check("ferr_count_timeout", ferr, 1);

        send_byte(8'h11);
        repeat (TMO - 2) @(posedge clk);
        send_byte(8'h22);
        send_tail(8'h11, 8'h22, 8'h20, 8'h33);
        finish_tx();
        check("ferr_edge_suppressed", ferr, 1);

        send3(8'h0F, 8'h01, 8'h20, 8'h10);
        send_byte(8'hAA);
        finish_tx();
        check("overrun_count", ovr, 1);
        send3(8'h01, 8'h01, 8'h20, 8'h02);
        finish_tx();

        for (int k = 0; k < 4; k++) begin
            send3(ta[k], tb[k], to[k], tr[k]);
            finish_tx();
        end
        send3(8'h80, 8'h02, 8'h02, 8'h20);
        finish_tx();

        send_byte(8'h03);
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        check_cleared("reset_mid_frame");
        @(negedge clk);
        rst_n = 1'b1;
        send3(8'h03, 8'h03, 8'h26, 8'h00);
        finish_tx();

        send3(8'h05, 8'h03, 8'h20, 8'h08);
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        check_cleared("reset_mid_tx");
        @(negedge clk);
        rst_n = 1'b1;
        r0 = nres;
        repeat (10) @(negedge clk);
        #1;
        check("no_result_after_reset", nres, r0);
        check("idle_after_reset", o_busy, 0);
        send3(8'h07, 8'h01, 8'h22, 8'h06);
        finish_tx();

`ifdef ALU_UART_CHECKSUM_EN
        r0 = nres;
        send_byte(8'h05);
        send_byte(8'h03);
        send_byte(8'h20);
        send_byte(8'h27);
        @(negedge clk);
        check("chk_bad_ferr", o_frame_err, 1);
        repeat (5) @(negedge clk);
        #1;
        check("chk_bad_no_result", nres, r0);
        send3(8'h05, 8'h03, 8'h20, 8'h08);
        finish_tx();
`endif

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
